dsp_dot_seq: RTL and testbench
==============================

# dsp_dot_seq

Upstream sequencer for the DSP MAC slice: accepts a job length, streams operand pairs over a valid/ready interface into the DSP, and controls accumulation so each job starts from a clean sum. It waits out the DSP pipeline latency, captures the final accumulator value, and presents it on a valid/ready result port. It sits directly in front of `DSP`, drives its `EN`/`ACC_EN`/`ACC_IN_EN`/`OP1`/`OP2` and reads back its `OUT`.

## Interface
- `WIDTH_OP1`, 18: operand 1 width, signed.
- `WIDTH_OP2`, 25: operand 2 width, signed.
- `WIDTH_OUT`, 48: DSP result width, signed.
- `LEN_W`, 8: job length counter width.
- `MAC_LAT`, 2: CLK edges from the DSP sampling `OP1`/`OP2` until `OUT` includes that product; ≥1.
- `CLK` in 1: single clock, rising edge.
- `RSTN` in 1: reset, asynchronous, active-low.
- `START` in 1: begin job; honoured only in IDLE.
- `LEN` in LEN_W: number of operand pairs; sampled with `START`.
- `BUSY` out 1: high in any state except IDLE.
- `IN_VALID` in 1, `IN_READY` out 1: operand handshake.
- `IN_OP1` in WIDTH_OP1, `IN_OP2` in WIDTH_OP2: operand pair.
- `DSP_EN`, `DSP_ACC_EN`, `DSP_ACC_IN_EN` out 1: DSP controls. `DSP_ACC_IN_EN` is constant 0.
- `DSP_OP1` out WIDTH_OP1, `DSP_OP2` out WIDTH_OP2: registered operands to the DSP.
- `DSP_OUT` in WIDTH_OUT: DSP result.
- `RES_VALID` out 1, `RES_READY` in 1: result handshake.
- `RES_DATA` out WIDTH_OUT: captured dot product.

## Operation
- States: IDLE, STREAM, DRAIN, HOLD.
- IDLE:
  - `START` with `LEN!=0` → STREAM; latch `LEN` into the remaining count and clear the `first` flag.
  - `START` with `LEN==0` → HOLD with `RES_DATA=0`. The DSP is never enabled.
- STREAM:
  - `IN_READY=1`, `DSP_EN=1`.
  - Handshake (`IN_VALID&&IN_READY`): register `IN_OP1`/`IN_OP2` into `DSP_OP1`/`DSP_OP2`. Set `DSP_ACC_EN=0` if this is the job's first pair, else 1. Decrement the count.
  - Bubble cycle: `DSP_OP1`/`DSP_OP2` are 0. `DSP_ACC_EN` equals the `first`-issued flag, so a zero product is added and the sum is unchanged.
  - On the last handshake → DRAIN, with the drain counter loaded to `MAC_LAT`.
- DRAIN:
  - `IN_READY=0`, `DSP_EN=1`, operands 0, `DSP_ACC_EN=1`.
  - Decrement each cycle. When the counter reads 0: capture `DSP_OUT` → `RES_DATA`, then go to HOLD.
- HOLD:
  - `RES_VALID=1`, `DSP_EN=0`.
  - `RES_DATA` is stable until `RES_READY`, then → IDLE.
  - `START` is ignored, even when it coincides with `RES_READY`.
- No width arithmetic is done here. `RES_DATA` is `DSP_OUT` bit-exact; overflow is the DSP's concern.

## Timing
- Reset (async assert): state IDLE. `BUSY`, `IN_READY`, `DSP_EN`, `DSP_ACC_EN`, `DSP_ACC_IN_EN`, `RES_VALID` are 0; `DSP_OP1`, `DSP_OP2`, `RES_DATA` are 0; all counters are 0.
- Reset mid-job aborts the job with no result. The next job's first-pair `ACC_EN=0` discards the stale DSP sum.
- `START` at edge s → `BUSY=1` after edge s. The first `IN_READY` is the cycle after s.
- Last handshake at edge t0 → `RES_VALID=1` after edge t0+MAC_LAT+1.
- Zero-length job: `RES_VALID=1` after the `START` edge.
- Throughput: one pair per cycle. Back-to-back jobs incur at least MAC_LAT+3 cycles between a last pair and the next first pair.

## Structure
- Shared package `dsp_pkg`:
  - state enum `dot_seq_state_t`.
  - default `WIDTH_OP1`/`WIDTH_OP2`/`WIDTH_OUT` constants, shared with `DSP`.
  - `MAC_LAT_DEFAULT`.
- Single module, no sub-module. `DSP` is instantiated beside it by the parent, not inside.

## Test plan
Bench instantiates `dsp_dot_seq` + `DSP` with matching `MAC_LAT`.
- LEN=3, back-to-back pairs (2,3),(−4,5),(7,−1) → `RES_DATA=−21`, `RES_VALID` exactly MAC_LAT+1 cycles after the 3rd handshake.
- Same pairs with `IN_VALID` low for 2 cycles between each pair → `RES_DATA=−21`, and `DSP_OP1`/`DSP_OP2` are 0 in bubbles.
- Job A as above, then job B with LEN=2 and pairs (1,1),(1,1) → B result `2`, with no carry-over of −21.
- `START` with LEN=0 → `RES_VALID=1`, `RES_DATA=0` one cycle later, and `DSP_EN` never asserted.
- Hold `RES_READY=0` for 5 cycles with `START` pulsed → `RES_DATA` stable, `IN_READY=0`, no new job. On `RES_READY=1` → IDLE.
- `RSTN` low for 1 cycle after 2 of 4 pairs → all outputs 0 immediately. A new LEN=1 job with (−131072,3) → `RES_DATA=−393216`.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP MAC slice and the dot-product sequencer in front of it.
package dsp_pkg;

  localparam int WIDTH_OP1_DEFAULT = 18;
  localparam int WIDTH_OP2_DEFAULT = 25;
  localparam int WIDTH_OUT_DEFAULT = 48;
  localparam int LEN_W_DEFAULT     = 8;
  localparam int MAC_LAT_DEFAULT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HOLD   = 2'd3
  } dot_seq_state_t;

endpackage

// File: rtl/dsp_dot_seq.sv
// Dot-product job sequencer: streams operand pairs into the DSP MAC, waits out its
// pipeline latency, captures the accumulated sum and offers it on a result port.
module dsp_dot_seq
  import dsp_pkg::*;
#(
  parameter int WIDTH_OP1 = WIDTH_OP1_DEFAULT,
  parameter int WIDTH_OP2 = WIDTH_OP2_DEFAULT,
  parameter int WIDTH_OUT = WIDTH_OUT_DEFAULT,
  parameter int LEN_W     = LEN_W_DEFAULT,
  parameter int MAC_LAT   = MAC_LAT_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START,
  input  logic [LEN_W-1:0]     LEN,
  output logic                 BUSY,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH_OP1-1:0] IN_OP1,
  input  logic [WIDTH_OP2-1:0] IN_OP2,
  output logic                 DSP_EN,
  output logic                 DSP_ACC_EN,
  output logic                 DSP_ACC_IN_EN,
  output logic [WIDTH_OP1-1:0] DSP_OP1,
  output logic [WIDTH_OP2-1:0] DSP_OP2,
  input  logic [WIDTH_OUT-1:0] DSP_OUT,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [WIDTH_OUT-1:0] RES_DATA,
  output dot_seq_state_t       DBG_STATE
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both
  // high. IN_READY depends only on state, never on IN_VALID; RES_VALID stays high
  // with RES_DATA frozen until RES_READY is seen.

  localparam int DRN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  dot_seq_state_t       r_state;
  dot_seq_state_t       w_next;
  logic [LEN_W-1:0]     r_remain;
  logic [DRN_W-1:0]     r_drain;
  logic                 r_first;
  logic                 r_acc_en;
  logic [WIDTH_OP1-1:0] r_op1;
  logic [WIDTH_OP2-1:0] r_op2;
  logic [WIDTH_OUT-1:0] r_res;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_busy;
  logic                 w_in_ready;
  logic                 w_dsp_en;
  logic                 w_res_valid;

  assign w_hs   = IN_VALID && w_in_ready;
  assign w_last = (r_remain == LEN_W'(1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b1;
    w_in_ready  = 1'b0;
    w_dsp_en    = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (START) begin
          w_next = (LEN != '0) ? ST_STREAM : ST_HOLD;
        end
      end
      ST_STREAM: begin
        w_in_ready = 1'b1;
        w_dsp_en   = 1'b1;
        if (IN_VALID && w_last) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_dsp_en = 1'b1;
        if (r_drain == '0) begin
          w_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_res_valid = 1'b1;
        if (RES_READY) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operands and ACC_EN are registered together so the DSP samples them as one
  // beat; a bubble feeds a zero product that cannot disturb the running sum.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_remain <= '0;
      r_drain  <= '0;
      r_first  <= 1'b0;
      r_acc_en <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_res    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_op1    <= '0;
          r_op2    <= '0;
          r_acc_en <= 1'b0;
          if (START) begin
            r_remain <= LEN;
            r_first  <= 1'b0;
            if (LEN == '0) begin
              r_res <= '0;
            end
          end
        end
        ST_STREAM: begin
          r_acc_en <= r_first;
          if (w_hs) begin
            r_op1    <= IN_OP1;
            r_op2    <= IN_OP2;
            r_first  <= 1'b1;
            r_remain <= r_remain - LEN_W'(1);
            if (w_last) begin
              r_drain <= DRN_W'(MAC_LAT);
            end
          end else begin
            r_op1 <= '0;
            r_op2 <= '0;
          end
        end
        ST_DRAIN: begin
          r_op1    <= '0;
          r_op2    <= '0;
          r_acc_en <= 1'b1;
          if (r_drain == '0) begin
            r_res <= DSP_OUT;
          end else begin
            r_drain <= r_drain - DRN_W'(1);
          end
        end
        ST_HOLD: begin
          r_op1    <= '0;
          r_op2    <= '0;
          r_acc_en <= 1'b0;
        end
        default: begin
          r_op1    <= '0;
          r_op2    <= '0;
          r_acc_en <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY          = w_busy;
  assign IN_READY      = w_in_ready;
  assign DSP_EN        = w_dsp_en;
  assign DSP_ACC_EN    = r_acc_en;
  assign DSP_ACC_IN_EN = 1'b0;
  assign DSP_OP1       = r_op1;
  assign DSP_OP2       = r_op2;
  assign RES_VALID     = w_res_valid;
  assign RES_DATA      = r_res;
  assign DBG_STATE     = r_state;

endmodule

// File: tb/tb_dsp_dot_seq.sv
// Directed bench for dsp_dot_seq driving a small behavioural DSP MAC model.
module tb_dsp_dot_seq;
  import dsp_pkg::*;

  localparam int W1  = 18;
  localparam int W2  = 25;
  localparam int WO  = 48;
  localparam int LW  = 8;
  localparam int LAT = 2;

  logic                 clk;
  logic                 rstn;
  logic                 start;
  logic [LW-1:0]        len;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [W1-1:0]        in_op1;
  logic [W2-1:0]        in_op2;
  logic                 dsp_en;
  logic                 dsp_acc_en;
  logic                 dsp_acc_in_en;
  logic signed [W1-1:0] dsp_op1;
  logic signed [W2-1:0] dsp_op2;
  logic signed [WO-1:0] dsp_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [WO-1:0]        res_data;
  dot_seq_state_t       dbg_state;

  int n_errors = 0;
  int n_checks = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int t_hs     = 0;

  dsp_dot_seq #(
    .WIDTH_OP1(W1), .WIDTH_OP2(W2), .WIDTH_OUT(WO), .LEN_W(LW), .MAC_LAT(LAT)
  ) dut (
    .CLK(clk), .RSTN(rstn), .START(start), .LEN(len), .BUSY(busy),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_OP1(in_op1), .IN_OP2(in_op2),
    .DSP_EN(dsp_en), .DSP_ACC_EN(dsp_acc_en), .DSP_ACC_IN_EN(dsp_acc_in_en),
    .DSP_OP1(dsp_op1), .DSP_OP2(dsp_op2), .DSP_OUT(dsp_out),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data),
    .DBG_STATE(dbg_state)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dsp_en) en_cnt <= en_cnt + 1;

  // DSP model for LAT=2: sample stage, then accumulate stage. Not reset by rstn.
  logic signed [WO-1:0] dsp_p = '0;
  logic                 dsp_a = 1'b0;
  initial dsp_out = '0;
  always @(posedge clk) begin
    if (dsp_en) begin
      dsp_p   <= WO'(dsp_op1 * dsp_op2);
      dsp_a   <= dsp_acc_en;
      dsp_out <= dsp_a ? dsp_out + dsp_p : dsp_p;
    end
  end

  task automatic check(input string tag, input logic [WO-1:0] got, input logic [WO-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag,
               $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [LW-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input string tag, input logic signed [W1-1:0] a,
                           input logic signed [W2-1:0] b, input int gap);
    int k;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      tick();
      if (g == 0) begin
        check({tag, "_bubble_op1"}, WO'(dsp_op1), '0);
        check({tag, "_bubble_op2"}, WO'(dsp_op2), '0);
      end
    end
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) check({tag, "_in_ready_timeout"}, WO'(in_ready), WO'(1));
    tick();
    t_hs     = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [WO-1:0] exp);
    int k;
    k = 0;
    while (!res_valid && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, WO'(res_valid), WO'(1));
    check({tag, "_latency"}, WO'(cyc - t_hs), WO'(LAT + 1));
    check({tag, "_data"}, res_data, exp);
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_idle"}, WO'(dbg_state), WO'(ST_IDLE));
    check({tag, "_not_busy"}, WO'(busy), '0);
  endtask

  initial begin
    int en_snap;
    rstn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_op1 = '0; in_op2 = '0; res_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", WO'(busy), '0);
    check("rst_in_ready", WO'(in_ready), '0);
    check("rst_dsp_en", WO'(dsp_en), '0);
    check("rst_acc_en", WO'(dsp_acc_en), '0);
    check("rst_acc_in_en", WO'(dsp_acc_in_en), '0);
    check("rst_res_valid", WO'(res_valid), '0);
    check("rst_op1", WO'(dsp_op1), '0);
    check("rst_op2", WO'(dsp_op2), '0);
    check("rst_res_data", res_data, '0);
    rstn = 1'b1;
    tick();

    // Job A, back-to-back pairs: 6 - 20 - 7 = -21
    start_job(3);
    check("a_busy", WO'(busy), WO'(1));
    check("a_in_ready", WO'(in_ready), WO'(1));
    send_pair("a0", 2, 3, 0);
    check("a0_op1", WO'(dsp_op1), WO'(2));
    check("a0_acc_en_first", WO'(dsp_acc_en), '0);
    send_pair("a1", -4, 5, 0);
    check("a1_acc_en", WO'(dsp_acc_en), WO'(1));
    send_pair("a2", 7, -1, 0);
    check("a2_in_ready_drain", WO'(in_ready), '0);
    wait_result("a", -21);
    take_result("a");

    // Same pairs with 2-cycle bubbles between them
    start_job(3);
    send_pair("g0", 2, 3, 2);
    send_pair("g1", -4, 5, 2);
    send_pair("g2", 7, -1, 2);
    wait_result("g", -21);
    take_result("g");

    // Job B right after: must not carry the previous -21
    start_job(2);
    send_pair("b0", 1, 1, 0);
    send_pair("b1", 1, 1, 0);
    wait_result("b", 2);

    // Result held with START pulsed: nothing moves
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 8'd5;
      tick();
      check("h_data", res_data, 2);
      check("h_in_ready", WO'(in_ready), '0);
      check("h_state", WO'(dbg_state), WO'(ST_HOLD));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    check("h_release_idle", WO'(dbg_state), WO'(ST_IDLE));
    tick();
    check("h_no_new_job", WO'(busy), '0);

    // Zero-length job
    en_snap = en_cnt;
    start_job(0);
    check("z_valid", WO'(res_valid), WO'(1));
    check("z_data", res_data, '0);
    check("z_in_ready", WO'(in_ready), '0);
    take_result("z");
    check("z_dsp_en_never", WO'(en_cnt - en_snap), '0);

    // Reset mid-job after 2 of 4 pairs
    start_job(4);
    send_pair("r0", 5, 6, 0);
    send_pair("r1", 7, 8, 0);
    rstn = 1'b0;
    #1;
    check("r_busy", WO'(busy), '0);
    check("r_in_ready", WO'(in_ready), '0);
    check("r_dsp_en", WO'(dsp_en), '0);
    check("r_acc_en", WO'(dsp_acc_en), '0);
    check("r_op1", WO'(dsp_op1), '0);
    check("r_op2", WO'(dsp_op2), '0);
    check("r_res_valid", WO'(res_valid), '0);
    check("r_res_data", res_data, '0);
    tick();
    rstn = 1'b1;
    tick();
    check("r_idle", WO'(dbg_state), WO'(ST_IDLE));

    // One-pair job after the abort: stale DSP sum must be discarded
    start_job(1);
    send_pair("n0", -131072, 3, 0);
    wait_result("n", -393216);
    take_result("n");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
